mac_out_drain: RTL and testbench
================================

Name: mac_out_drain

Overview:
- Consumer at the output end of the MAC bank.
- Captures one vector of N_MAC signed accumulator results per vld_i pulse, adds the shared bias, then rounds, shifts and saturates each result to 8 bits.
- Buffers up to two vectors (ping-pong) and streams each as LANES-byte beats over a valid/ready interface toward the activation buffer writer.
- Reports drops when the bank fires while both buffers are full.

Parameters:
- N_MAC, 12, results per vector; must be a multiple of LANES
- ACC_W, 20, signed accumulator width per result
- BIAS_W, 16, signed bias width
- LANES, 4, bytes per output beat; beats per vector = N_MAC/LANES (3 by default)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- vld_i  in  1  accumulator vector valid, single-cycle pulse per vector
- iAcc  in  N_MAC*ACC_W  result k occupies bits [k*ACC_W +: ACC_W]
- iBias  in  BIAS_W  signed bias, sampled with vld_i
- iShift  in  4  right-shift amount 0..15, sampled with vld_i
- rdy_o  out  1  a buffer entry is free
- oData  out  LANES*8  output beat; lane j = bits [8j+7:8j]
- oValid  out  1  oData valid
- iReady  in  1  downstream accepts beat
- oLast  out  1  final beat of a vector
- oOvf  out  1  sticky drop flag, cleared only by rst

Behaviour:
- Reset: while rst is high at a clock edge, oValid, oLast, oOvf, oData and rdy_o are 0. Both buffers are emptied, the beat counter is 0 and the FSM is in IDLE. rdy_o is 1 from the first cycle after rst deasserts. Reset mid-vector drops all buffered data; no further beats or oLast are emitted.
- Capture: vld_i & rdy_o at an edge writes the quantized vector into the write-pointer entry; the write pointer then toggles.
- If vld_i is high and rdy_o is low, the vector is discarded and oOvf is set.
- Quantize, per result k:
  - s = sext(acc_k) + sext(iBias), 22-bit signed.
  - If iShift > 0, add 1 << (iShift-1) (round half up).
  - Arithmetic right shift by iShift.
  - Saturate to [-128, 127]; store as two's complement byte.
- Occupancy count 0..2:
  - +1 on capture.
  - -1 on the last-beat handshake.
  - Both in the same cycle: count unchanged.
  - rdy_o = (count < 2), computed from the registered count with no same-cycle bypass. A full buffer stays not-ready during its freeing cycle.
- FSM:
  - IDLE: when count > 0, load beat 0 of the read entry into the oData register and go to SEND.
  - SEND: oValid = 1.
    - On oValid & iReady with beat < last: beat++ and load the next beat.
    - On the last beat with handshake: free the entry and toggle the read pointer. If another entry is buffered (including one captured this cycle), load its beat 0 and stay in SEND; otherwise go to IDLE.
- Beat b, lane j carries result index b*LANES + j.
- oLast = oValid & (beat == N_MAC/LANES - 1).
- While oValid is high and iReady is low, oData, oLast and oValid hold stable.
- Latency: vld_i sampled at edge E0 gives the first beat valid after edge E1 (2 cycles) if the output is idle. Throughput is one beat per cycle with iReady held high.

Optional Feature:
- Macro: MAC_OUT_RELU_EN.
- Defined: after saturation, negative bytes are forced to 0 (ReLU); output range is [0, 127].
- Undefined: signed bytes are passed unchanged.

Test Plan:
- Single vector, iReady=1:
  - Stimulus: acc0=100, acc1=1000, acc2=-1000, acc3=-6, others 0; iBias=0; iShift=2.
  - Response: beat0 lanes = 25, 127 (sat), -128 (sat), -1; beats 1-2 all zero; oLast on the 3rd beat; oValid 2 cycles after vld_i.
- Bias and rounding:
  - Stimulus: acc0=1000, iBias=24, iShift=3.
  - Response: (1024+4)>>3=128, saturating to 0x7F.
  - Stimulus: iShift=0, acc0=-128, iBias=0.
  - Response: 0x80.
- Backpressure:
  - Stimulus: iReady low for 5 cycles mid-beat 1.
  - Response: oData and oLast stable throughout; beat order 0,1,2 preserved.
- Overflow:
  - Stimulus: three vld_i pulses back-to-back with iReady=0.
  - Response: first two captured; rdy_o falls after the 2nd; oOvf=1; the two vectors drain in capture order with 6 beats total.
- Simultaneous capture and free:
  - Stimulus: count=2 with the last beat handshaking; vld_i is rejected that cycle (rdy_o=0).
  - Stimulus: count=1 with the last beat handshaking while vld_i is high.
  - Response: the vector is accepted, count stays 1, and the next vector's beat 0 follows with no idle cycle.
- Reset and ReLU:
  - Stimulus: rst asserted during beat 1.
  - Response: next cycle oValid=0, oOvf=0; a new vector afterwards streams from beat 0.
  - Stimulus: with MAC_OUT_RELU_EN defined, acc=-6, iShift=2.
  - Response: lane byte 0x00.

Source files
------------

// File: rtl/mac_out_drain.sv
// mac_out_drain: output stage of the MAC bank.
// Captures a vector of N_MAC signed accumulators per vld_i pulse, adds a shared
// bias, rounds/shifts/saturates each result to a byte, holds up to two vectors
// in a ping-pong buffer and streams them as LANES-byte beats over valid/ready.
// Optional build macro: MAC_OUT_RELU_EN (clamps negative output bytes to zero).
module mac_out_drain #(
    parameter int unsigned N_MAC  = 12,
    parameter int unsigned ACC_W  = 20,
    parameter int unsigned BIAS_W = 16,
    parameter int unsigned LANES  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vld_i,
    input  logic [N_MAC*ACC_W-1:0] iAcc,
    input  logic [BIAS_W-1:0]      iBias,
    input  logic [3:0]             iShift,
    output logic                   rdy_o,
    output logic [LANES*8-1:0]     oData,
    output logic                   oValid,
    input  logic                   iReady,
    output logic                   oLast,
    output logic                   oOvf
);

    localparam int unsigned SUM_W     = 22;
    localparam int unsigned VEC_W     = N_MAC * 8;
    localparam int unsigned BEAT_BITS = LANES * 8;
    localparam int unsigned BEATS     = N_MAC / LANES;
    localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [BEAT_W-1:0]       LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX   = SUM_W'(127);
    localparam logic signed [SUM_W-1:0] SAT_MIN   = SUM_W'(-128);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BEAT_W-1:0]   r_beat;
    logic [BEAT_W-1:0]   w_beat_nxt;
    logic [BEAT_BITS-1:0] r_data;
    logic [BEAT_BITS-1:0] w_data_nxt;
    logic [VEC_W-1:0]    r_buf [2];
    logic [VEC_W-1:0]    w_q;
    logic                r_wptr;
    logic                r_rptr;
    logic [1:0]          r_cnt;
    logic [1:0]          w_cnt_nxt;
    logic                r_rdy;
    logic                r_ovf;
    logic                w_cap;
    logic                w_drop;
    logic                w_free;

    // Bias add, round-half-up, arithmetic shift and saturate one result to a byte.
    function automatic logic [7:0] quant(input logic [ACC_W-1:0]  acc,
                                         input logic [BIAS_W-1:0] bias,
                                         input logic [3:0]        sh);
        logic signed [SUM_W-1:0] s;
        logic [7:0]              q;
        s = SUM_W'($signed(acc)) + SUM_W'($signed(bias));
        if (sh != 4'd0) begin
            s = s + (SUM_W'(1) << (sh - 4'd1));
        end
        s = s >>> sh;
        if (s > SAT_MAX) begin
            q = 8'h7F;
        end else if (s < SAT_MIN) begin
            q = 8'h80;
        end else begin
            q = s[7:0];
        end
`ifdef MAC_OUT_RELU_EN
        if (q[7]) begin
            q = 8'h00;
        end
`else
        q = q;
`endif
        return q;
    endfunction

    // Select one beat (LANES consecutive bytes) out of a buffered vector.
    function automatic logic [BEAT_BITS-1:0] beat_of(input logic [VEC_W-1:0]  v,
                                                     input logic [BEAT_W-1:0] b);
        return v[int'(b)*BEAT_BITS +: BEAT_BITS];
    endfunction

    assign w_cap  = vld_i & r_rdy;
    assign w_drop = vld_i & ~r_rdy;

    // Quantize the incoming accumulator vector.
    always_comb begin
        w_q = '0;
        for (int k = 0; k < int'(N_MAC); k++) begin
            w_q[k*8 +: 8] = quant(iAcc[k*ACC_W +: ACC_W], iBias, iShift);
        end
    end

    // Streaming FSM: beat sequencing, output data load and entry release.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_data_nxt  = r_data;
        w_free      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_cnt != 2'd0) begin
                    w_beat_nxt  = '0;
                    w_data_nxt  = beat_of(r_buf[r_rptr], '0);
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (iReady) begin
                    if (r_beat != LAST_BEAT) begin
                        w_beat_nxt = r_beat + 1'b1;
                        w_data_nxt = beat_of(r_buf[r_rptr], w_beat_nxt);
                    end else begin
                        w_free     = 1'b1;
                        w_beat_nxt = '0;
                        if (r_cnt == 2'd2) begin
                            w_data_nxt = beat_of(r_buf[~r_rptr], '0);
                        end else if (w_cap) begin
                            // Vector landing this cycle feeds beat 0 directly.
                            w_data_nxt = beat_of(w_q, '0);
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Occupancy update; a capture and a release in the same cycle cancel.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_cap && !w_free) begin
            w_cnt_nxt = r_cnt + 2'd1;
        end else if (!w_cap && w_free) begin
            w_cnt_nxt = r_cnt - 2'd1;
        end
    end

    // State, buffers, pointers and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_beat   <= '0;
            r_data   <= '0;
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_cnt    <= 2'd0;
            r_rdy    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_data  <= w_data_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rdy   <= (w_cnt_nxt != 2'd2);
            if (w_cap) begin
                r_buf[r_wptr] <= w_q;
                r_wptr        <= ~r_wptr;
            end
            if (w_free) begin
                r_rptr <= ~r_rptr;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign rdy_o  = r_rdy;
    assign oData  = r_data;
    assign oValid = (r_state == S_SEND);
    assign oLast  = (r_state == S_SEND) && (r_beat == LAST_BEAT);
    assign oOvf   = r_ovf;

endmodule

// File: tb/tb_mac_out_drain.sv
// Scoreboard bench for mac_out_drain: stimulus pushes hand-computed beats into
// a queue, an independent monitor pops and compares on every handshake.
module tb_mac_out_drain;

    localparam int unsigned N_MAC  = 12;
    localparam int unsigned ACC_W  = 20;
    localparam int unsigned BIAS_W = 16;
    localparam int unsigned LANES  = 4;

`ifdef MAC_OUT_RELU_EN
    localparam logic [7:0] NEG128 = 8'h00;
    localparam logic [7:0] NEG1   = 8'h00;
`else
    localparam logic [7:0] NEG128 = 8'h80;
    localparam logic [7:0] NEG1   = 8'hFF;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   vld_i;
    logic [N_MAC*ACC_W-1:0] iAcc;
    logic [BIAS_W-1:0]      iBias;
    logic [3:0]             iShift;
    logic                   rdy_o;
    logic [LANES*8-1:0]     oData;
    logic                   oValid;
    logic                   iReady;
    logic                   oLast;
    logic                   oOvf;

    typedef struct packed {
        logic [31:0] d;
        logic        last;
    } beat_t;

    beat_t q[$];
    int    errors = 0;
    int    checks = 0;
    int    beats_seen = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] hold_d = '0;
    logic        hold_l = 1'b0;

    always #5 clk = ~clk;

    mac_out_drain #(
        .N_MAC (N_MAC),
        .ACC_W (ACC_W),
        .BIAS_W(BIAS_W),
        .LANES (LANES)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .vld_i (vld_i),
        .iAcc  (iAcc),
        .iBias (iBias),
        .iShift(iShift),
        .rdy_o (rdy_o),
        .oData (oData),
        .oValid(oValid),
        .iReady(iReady),
        .oLast (oLast),
        .oOvf  (oOvf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every accepted beat and check stability while stalled.
    always @(negedge clk) begin : monitor
        beat_t e;
        if (!rst) begin
            if (stall_prev && oValid) begin
                check("hold_data", oData, hold_d);
                check("hold_last", 32'(oLast), 32'(hold_l));
            end
            if (oValid && iReady) begin
                beats_seen++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got 0x%0h expected none", oData);
                end else begin
                    e = q.pop_front();
                    check("beat_data", oData, e.d);
                    check("beat_last", 32'(oLast), 32'(e.last));
                end
            end
            stall_prev = oValid && !iReady;
            hold_d     = oData;
            hold_l     = oLast;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [N_MAC*ACC_W-1:0] a, input logic [BIAS_W-1:0] b,
                         input logic [3:0] s);
        iAcc   = a;
        iBias  = b;
        iShift = s;
        vld_i  = 1'b1;
        tick();
        vld_i  = 1'b0;
    endtask

    task automatic push_exp(input logic [N_MAC*8-1:0] e);
        for (int b = 0; b < 3; b++) begin
            q.push_back('{d: e[b*32 +: 32], last: (b == 2)});
        end
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((q.size() != 0 || oValid) && n < limit) begin
            tick();
            n++;
        end
        check("drain_done", 32'(q.size() == 0 && !oValid), 32'd1);
    endtask

    task automatic wait_last(input int limit);
        int n = 0;
        while (!(oValid && oLast) && n < limit) begin
            tick();
            n++;
        end
        check("last_seen", 32'(oValid && oLast), 32'd1);
    endtask

    function automatic logic [N_MAC*ACC_W-1:0] mk_acc(input int a0, input int a1,
                                                      input int a2, input int a3);
        logic [N_MAC*ACC_W-1:0] v;
        v = '0;
        v[0  +: 20] = 20'(a0);
        v[20 +: 20] = 20'(a1);
        v[40 +: 20] = 20'(a2);
        v[60 +: 20] = 20'(a3);
        return v;
    endfunction

    function automatic logic [N_MAC*8-1:0] mk_exp(input logic [7:0] e0, input logic [7:0] e1,
                                                  input logic [7:0] e2, input logic [7:0] e3,
                                                  input logic [7:0] rest);
        logic [N_MAC*8-1:0] v;
        v = '0;
        v[0 +: 8]  = e0;
        v[8 +: 8]  = e1;
        v[16 +: 8] = e2;
        v[24 +: 8] = e3;
        for (int k = 4; k < 12; k++) v[k*8 +: 8] = rest;
        return v;
    endfunction

    initial begin
        logic [N_MAC*ACC_W-1:0] acc_bp;
        logic [N_MAC*8-1:0]     exp_bp;
        int bs;

        rst    = 1'b1;
        vld_i  = 1'b0;
        iAcc   = '0;
        iBias  = '0;
        iShift = '0;
        iReady = 1'b1;
        repeat (3) tick();
        check("rst_valid", 32'(oValid), 32'd0);
        check("rst_last",  32'(oLast),  32'd0);
        check("rst_ovf",   32'(oOvf),   32'd0);
        check("rst_data",  oData,       32'd0);
        check("rst_rdy",   32'(rdy_o),  32'd0);
        rst = 1'b0;
        tick();
        tick();
        check("rdy_after_rst", 32'(rdy_o), 32'd1);

        // Saturation and rounding of a single vector, plus 2-cycle latency.
        push_exp(mk_exp(8'd25, 8'h7F, NEG128, NEG1, 8'h00));
        pulse(mk_acc(100, 1000, -1000, -6), 16'd0, 4'd2);
        check("lat_e0_valid", 32'(oValid), 32'd0);
        tick();
        check("lat_e1_valid", 32'(oValid), 32'd1);
        wait_drain(20);

        // Bias with rounding: (1000+24+4)>>3 saturates; zero lanes give (24+4)>>3 = 3.
        push_exp(mk_exp(8'h7F, 8'd3, 8'd3, 8'd3, 8'd3));
        pulse(mk_acc(1000, 0, 0, 0), 16'd24, 4'd3);
        wait_drain(20);

        // No shift, no rounding: -128 passes straight through.
        push_exp(mk_exp(NEG128, 8'd0, 8'd0, 8'd0, 8'd0));
        pulse(mk_acc(-128, 0, 0, 0), 16'd0, 4'd0);
        wait_drain(20);

        // Backpressure for 5 cycles while beat 1 is presented.
        acc_bp = '0;
        exp_bp = '0;
        for (int k = 0; k < 12; k++) begin
            acc_bp[k*20 +: 20] = 20'(k + 1);
            exp_bp[k*8 +: 8]   = 8'(k + 1);
        end
        push_exp(exp_bp);
        pulse(acc_bp, 16'd0, 4'd0);
        tick();
        check("bp_valid", 32'(oValid), 32'd1);
        tick();
        iReady = 1'b0;
        repeat (5) tick();
        iReady = 1'b1;
        wait_drain(20);

        // Three back-to-back vectors while stalled: third is dropped.
        iReady = 1'b0;
        push_exp(mk_exp(8'd5, 8'd0, 8'd0, 8'd0, 8'd0));
        push_exp(mk_exp(8'd7, 8'd0, 8'd0, 8'd0, 8'd0));
        pulse(mk_acc(5, 0, 0, 0), 16'd0, 4'd0);
        check("ovf_rdy_1", 32'(rdy_o), 32'd1);
        pulse(mk_acc(7, 0, 0, 0), 16'd0, 4'd0);
        check("ovf_rdy_2", 32'(rdy_o), 32'd0);
        pulse(mk_acc(9, 0, 0, 0), 16'd0, 4'd0);
        check("ovf_flag", 32'(oOvf), 32'd1);
        bs = beats_seen;
        iReady = 1'b1;
        wait_drain(30);
        check("ovf_beats", 32'(beats_seen - bs), 32'd6);

        // Full buffer during its freeing cycle still rejects a new vector.
        iReady = 1'b0;
        push_exp(mk_exp(8'd11, 8'd0, 8'd0, 8'd0, 8'd0));
        push_exp(mk_exp(8'd12, 8'd0, 8'd0, 8'd0, 8'd0));
        pulse(mk_acc(11, 0, 0, 0), 16'd0, 4'd0);
        pulse(mk_acc(12, 0, 0, 0), 16'd0, 4'd0);
        tick();
        iReady = 1'b1;
        wait_last(20);
        check("full_free_rdy", 32'(rdy_o), 32'd0);
        pulse(mk_acc(13, 0, 0, 0), 16'd0, 4'd0);
        wait_drain(30);
        repeat (3) tick();
        check("full_free_idle", 32'(oValid), 32'd0);

        // Capture during last-beat release with one entry: back-to-back beats.
        push_exp(mk_exp(8'd21, 8'd0, 8'd0, 8'd0, 8'd0));
        push_exp(mk_exp(8'd22, 8'd0, 8'd0, 8'd0, 8'd0));
        pulse(mk_acc(21, 0, 0, 0), 16'd0, 4'd0);
        wait_last(20);
        check("one_free_rdy", 32'(rdy_o), 32'd1);
        pulse(mk_acc(22, 0, 0, 0), 16'd0, 4'd0);
        check("no_gap_valid", 32'(oValid), 32'd1);
        check("no_gap_last",  32'(oLast),  32'd0);
        check("no_gap_rdy",   32'(rdy_o),  32'd1);
        wait_drain(20);

        // Reset while beat 1 is presented flushes everything.
        push_exp(mk_exp(8'd31, 8'd0, 8'd0, 8'd0, 8'd0));
        pulse(mk_acc(31, 0, 0, 0), 16'd0, 4'd0);
        tick();
        tick();
        iReady = 1'b0;
        rst    = 1'b1;
        tick();
        q.delete();
        check("mid_rst_valid", 32'(oValid), 32'd0);
        check("mid_rst_last",  32'(oLast),  32'd0);
        check("mid_rst_ovf",   32'(oOvf),   32'd0);
        rst    = 1'b0;
        iReady = 1'b1;
        tick();
        tick();
        check("post_rst_idle", 32'(oValid), 32'd0);
        push_exp(mk_exp(8'd41, 8'd42, 8'd43, 8'd44, 8'd0));
        pulse(mk_acc(41, 42, 43, 44), 16'd0, 4'd0);
        wait_drain(20);

        repeat (3) tick();
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
